// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op encodings, iteration count and FSM states for the multiply/divide unit
// Purpose: constants shared by the multiply/divide unit and the control-unit decoder.
package mult_div_unit_pkg;

    localparam int MD_WIDTH = 32;
    // One iteration per operand bit; tied to the width on purpose.
    localparam int MD_ITER  = MD_WIDTH;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the controller and the multiply/divide unit
// Ports: start/op/rs/rt request, hi_we/lo_we/wdata MTHI/MTLO writes, busy/done/hi/lo results.
// master = controller side, slave = multiply/divide unit side.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    import mult_div_unit_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// rtl/mult_div_unit_sign_fix.sv - conditional two's-complement negation helper
// Ports: din (W bits), neg (negate when 1), dout = neg ? -din : din.
// Used for operand magnitudes on entry and for result sign correction.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);
    // -(2^(W-1)) maps back onto itself, which read as unsigned is exactly 2^(W-1).
    assign dout = neg ? (W'(0) - din) : din;
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-step multiply/divide unit producing HI/LO
// Ports: clk, rst (async, active high); md (slave): start/op/rs/rt request,
// hi_we/lo_we/wdata MTHI/MTLO, busy/done status, hi/lo result registers.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  md
);
    localparam int ITER = WIDTH;
    localparam int CW   = $clog2(ITER);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;          // negate product / quotient
    logic             neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] b_q, b_d;              // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;    // partial product upper half / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;    // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;

    assign op_signed = (md.op == OP_MULT) || (md.op == OP_DIV);

    md_sign_fix #(.W(WIDTH)) u_mag_a (
        .din(md.rs), .neg(op_signed & md.rs[WIDTH-1]), .dout(mag_a));
    md_sign_fix #(.W(WIDTH)) u_mag_b (
        .din(md.rt), .neg(op_signed & md.rt[WIDTH-1]), .dout(mag_b));
    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .din({acc_hi_q, acc_lo_q}), .neg(neg_q), .dout(prod_fix));
    md_sign_fix #(.W(WIDTH)) u_fix_quot (
        .din(acc_lo_q), .neg(neg_q), .dout(quot_fix));
    md_sign_fix #(.W(WIDTH)) u_fix_rem (
        .din(acc_hi_q), .neg(neg_rem_q), .dout(rem_fix));

    // Multiply step: add multiplicand when the outgoing multiplier bit is set, then shift right.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    // Divide step: shift the next dividend bit into the remainder and trial-subtract.
    // When rem_ge holds, rem_sh < 2*b so the difference fits in WIDTH bits.
    assign rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign rem_ge  = rem_sh >= {1'b0, b_q};
    assign rem_sub = rem_sh[WIDTH-1:0] - b_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md.start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CW'(ITER-1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        b_d       = b_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md.hi_we) hi_d = md.wdata;
                if (md.lo_we) lo_d = md.wdata;
                if (md.start) begin
                    cnt_d     = '0;
                    is_div_d  = md.op[1];
                    neg_d     = op_signed & (md.rs[WIDTH-1] ^ md.rt[WIDTH-1]);
                    neg_rem_d = op_signed & md.rs[WIDTH-1];
                    div0_d    = md.op[1] && (md.rt == '0);
                    acc_hi_d  = '0;
                    acc_lo_d  = md.op[1] ? mag_a : mag_b;
                    b_d       = md.op[1] ? mag_b : mag_a;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    acc_hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            ST_FIX: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    // Divide by zero leaves |rs| in the remainder; re-signing restores rs.
                    hi_d = rem_fix;
                    lo_d = div0_q ? '1 : quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            b_q       <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            b_q       <= b_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: begin
                q = sa * sb;
                return q;
            end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit now, output logic [31:0] rhi, output logic [31:0] rlo,
                          output int lat, output logic busy0);
        if (!now) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = md_op_e'(op);
        bus.rs    = a;
        bus.rt    = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        rhi = bus.hi;
        rlo = bus.lo;
    endtask

    initial begin
        logic [31:0] rhi, rlo, ra, rb;
        logic [63:0] exp;
        logic [1:0]  rop;
        logic        busy0;
        int          lat, done_seen;

        vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[5] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'h0000_0005, 32'h1999_9999};
        vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{2'b00, 32'd0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = OP_MULT; bus.rs = '0; bus.rt = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, rhi, rlo, lat, busy0);
            chk($sformatf("vec%0d_busy", i), 64'(busy0), 64'd1);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d_hi", i), 64'(rhi), 64'(vecs[i].hi));
            chk($sformatf("vec%0d_lo", i), 64'(rlo), 64'(vecs[i].lo));
        end

        // Back-to-back: new start issued in the done cycle of the previous op.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rhi, rlo, lat, busy0);
        chk("b2b_first_lo", 64'(rlo), 64'h1);
        chk("b2b_done_cycle", 64'(bus.done), 64'd1);
        run_op(2'b11, 32'd100, 32'd7, 1'b1, rhi, rlo, lat, busy0);
        chk("b2b_busy", 64'(busy0), 64'd1);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_res", {rhi, rlo}, {32'd2, 32'd14});

        // Writes and start during RUN are dropped; hi/lo hold.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs = 32'd1000; bus.rt = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.op = OP_MULT; bus.rs = 32'hDEAD_BEEF; bus.rt = 32'd3;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("run_hold", {bus.hi, bus.lo}, {32'd2, 32'd14});
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("run_ignore_res", {bus.hi, bus.lo}, {32'd6, 32'd142});

        // Asynchronous reset mid-divide, then MTLO.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.rs = 32'hFFFF_F000; bus.rt = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("arst_no_done", 64'(done_seen), 64'd0);
        bus.lo_we = 1'b1; bus.wdata = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo", {bus.hi, bus.lo}, {32'd0, 32'd5});

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
            exp = model(rop, ra, rb);
            run_op(rop, ra, rb, 1'b0, rhi, rlo, lat, busy0);
            chk($sformatf("rnd%0d_op%0d_%h_%h_lat", i, rop, ra, rb), 64'(lat), 64'd33);
            chk($sformatf("rnd%0d_op%0d_%h_%h_res", i, rop, ra, rb), {rhi, rlo}, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multicycle datapath. It produces 64-bit results into HI/LO for MULT/MULTU/DIV/DIVU.
- The controller issues a one-cycle start and then stalls on busy, the mirror of the single-cycle ALU result register path.
- HI/LO are readable at any time for MFHI/MFLO, and writable for MTHI/MTLO while idle.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles; not overridable independently of WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs  input  WIDTH  operand A (multiplicand or dividend)
- rt  input  WIDTH  operand B (multiplier or divisor)
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse; HI/LO updated
- hi  output  WIDTH  HI register (remainder / product upper half)
- lo  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - hi=0, lo=0, busy=0, done=0, FSM to IDLE, iteration counter=0.
  - An in-flight operation is discarded.
- FSM states are IDLE, RUN and FIX.
  - IDLE: start=1 at edge E0 latches op, |rs| and |rt| (magnitudes for signed ops, raw for unsigned) and the sign flags; goes to RUN with counter=0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. Edges E1..E32 perform the 32 iterations; leave to FIX when counter reaches ITER-1.
  - FIX: edge E33 applies sign correction, writes hi/lo, pulses done, returns to IDLE.
- Latency and handshake:
  - busy is 1 after E0 through the cycle before E33; busy=0 and done=1 in the cycle after E33.
  - Latency is fixed at 33 cycles from the start edge for every op, including divide-by-zero.
  - start while busy=1 is ignored, with no queuing.
  - start in the cycle done=1 is accepted (back-to-back).
- Signed rules:
  - MULT: negate the 64-bit product when the signs of rs and rt differ.
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=32'h80000000 (wrap), hi=0.
  - Magnitude of 32'h80000000 is handled as unsigned 2^31.
- Divide by zero (DIV or DIVU, rt=0): lo=32'hFFFFFFFF, hi=rs unmodified. No exception.
- MTHI/MTLO:
  - hi_we/lo_we write wdata at the edge only when busy=0 and the FSM is not in FIX.
  - While busy the writes are dropped.
  - If hi_we/lo_we coincide with an accepted start, the write lands now; the operation result later overwrites it.
- hi/lo hold their value during RUN. Intermediate accumulators are internal; outputs change only at FIX, on an MT write, or on reset.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared defines include file: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the ITER constant.
- These are reused by the control-unit decoder.
- One sub-module, md_sign_fix: combinational magnitude/negation helper, used on operand entry and on FIX.
- The FSM and datapath stay in mult_div_unit.

Test Plan:
- MULT rs=-3 (32'hFFFFFFFD), rt=7 -> done exactly 33 cycles after the start edge; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- MULTU rs=rt=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Immediate back-to-back start in the done cycle is accepted, and busy rises the next cycle.
- DIV rs=-7, rt=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV rs=32'h80000000, rt=-1 -> lo=32'h80000000, hi=0.
- DIVU rs=100, rt=0 -> lo=32'hFFFFFFFF, hi=32'h00000064 after 33 cycles.
- start, hi_we and lo_we during RUN are ignored (result unchanged). Asserting rst at cycle 10 of a DIV -> busy=0, hi=lo=0 immediately (asynchronous), no done pulse. A following MTLO wdata=5 gives lo=5.
